// File: rtl/dvp_tx_pkg.sv
// Shared types and width helpers for the 16-to-8 bit DVP transmitter.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4
  } tx_state_t;

  // First byte on the bus carries pixel bits [15:8].
  localparam bit HI_FIRST = 1'b1;

  localparam int unsigned PIX_W   = 16;
  localparam int unsigned ENTRY_W = PIX_W + 1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO of {sof, pixel}; full is decoded from the occupancy count only.
module pix_fifo2
  import dvp_tx_pkg::*;
(
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests so overflow and underflow cannot corrupt the pointers.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      mem_r[0] <= {ENTRY_W{1'b0}};
      mem_r[1] <= {ENTRY_W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dvp_16_8bit_tx.sv
// DVP transmitter: splits 16-bit pixels into two bus bytes and generates
// vsync/href framing around them.
module dvp_16_8bit_tx
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned VS_PULSE = 4,
  parameter int unsigned VS_BACK  = 8
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [15:0] s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  dvp_data,
  output logic        dvp_href,
  output logic        dvp_vsync,
  output logic        underrun,
  output logic        busy
);

  localparam int unsigned HCNT_W = cnt_width(2 * H_ACTIVE);
  localparam int unsigned VCNT_W = cnt_width(V_ACTIVE);
  localparam int unsigned TMR_W  = cnt_width(max3(VS_PULSE, VS_BACK, H_BLANK) + 1);

  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(2 * H_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_ACTIVE - 1);
  localparam logic [TMR_W-1:0]  VS_LAST = TMR_W'(VS_PULSE - 1);
  localparam logic [TMR_W-1:0]  VB_LAST = TMR_W'(VS_BACK - 1);
  localparam logic [TMR_W-1:0]  HB_LAST = TMR_W'(H_BLANK - 1);

  tx_state_t           state_r, state_nx_s;
  logic [HCNT_W-1:0]   hcnt_r, hcnt_nx_s;
  logic [VCNT_W-1:0]   vcnt_r, vcnt_nx_s;
  logic [TMR_W-1:0]    tmr_r, tmr_nx_s;
  logic                slot_empty_r, slot_empty_nx_s;
  logic                underrun_r, underrun_set_s;
  logic [7:0]          byte_s;
  logic [7:0]          dvp_data_r;
  logic                dvp_href_r;
  logic                dvp_vsync_r;
  logic                push_s;
  logic                pop_s;
  logic [ENTRY_W-1:0]  head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [1:0]          fifo_count_s;

  assign s_ready   = (fifo_count_s < 2'd2);
  assign push_s    = s_valid && !fifo_full_s;
  assign dvp_data  = dvp_data_r;
  assign dvp_href  = dvp_href_r;
  assign dvp_vsync = dvp_vsync_r;
  assign underrun  = underrun_r;
  assign busy      = (state_r != IDLE);

  pix_fifo2 u_fifo (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({s_sof, s_data}),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Next-state, counter and byte-select logic for the framing FSM.
  always_comb begin
    state_nx_s      = state_r;
    hcnt_nx_s       = hcnt_r;
    vcnt_nx_s       = vcnt_r;
    tmr_nx_s        = tmr_r;
    slot_empty_nx_s = slot_empty_r;
    underrun_set_s  = 1'b0;
    pop_s           = 1'b0;
    byte_s          = 8'h00;
    case (state_r)
      IDLE: begin
        hcnt_nx_s = {HCNT_W{1'b0}};
        vcnt_nx_s = {VCNT_W{1'b0}};
        tmr_nx_s  = {TMR_W{1'b0}};
        // Pixels without sof between frames are dropped; an sof head starts a frame.
        if (!fifo_empty_s) begin
          if (head_s[PIX_W]) begin
            state_nx_s = VSYNC;
          end else begin
            pop_s = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      VSYNC: begin
        if (tmr_r == VS_LAST) begin
          state_nx_s = VBACK;
          tmr_nx_s   = {TMR_W{1'b0}};
        end else begin
          tmr_nx_s = tmr_r + 1'b1;
        end
      end
      VBACK: begin
        if (tmr_r == VB_LAST) begin
          state_nx_s = ACTIVE;
          tmr_nx_s   = {TMR_W{1'b0}};
        end else begin
          tmr_nx_s = tmr_r + 1'b1;
        end
      end
      ACTIVE: begin
        // An empty slot is decided in phase 0 and stays empty for phase 1.
        if (!hcnt_r[0]) begin
          if (fifo_empty_s) begin
            slot_empty_nx_s = 1'b1;
            underrun_set_s  = 1'b1;
          end else begin
            slot_empty_nx_s = 1'b0;
            byte_s = HI_FIRST ? head_s[15:8] : head_s[7:0];
          end
        end else begin
          if (slot_empty_r) begin
            byte_s = 8'h00;
          end else begin
            byte_s = HI_FIRST ? head_s[7:0] : head_s[15:8];
            pop_s  = 1'b1;
          end
        end
        if (hcnt_r == H_LAST) begin
          state_nx_s = HBLANK;
          hcnt_nx_s  = {HCNT_W{1'b0}};
          tmr_nx_s   = {TMR_W{1'b0}};
        end else begin
          hcnt_nx_s = hcnt_r + 1'b1;
        end
      end
      HBLANK: begin
        if (tmr_r == HB_LAST) begin
          tmr_nx_s = {TMR_W{1'b0}};
          if (vcnt_r == V_LAST) begin
            state_nx_s = IDLE;
            vcnt_nx_s  = {VCNT_W{1'b0}};
          end else begin
            state_nx_s = ACTIVE;
            vcnt_nx_s  = vcnt_r + 1'b1;
          end
        end else begin
          tmr_nx_s = tmr_r + 1'b1;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, counters and the registered bus outputs (one cycle behind state).
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hcnt_r       <= {HCNT_W{1'b0}};
      vcnt_r       <= {VCNT_W{1'b0}};
      tmr_r        <= {TMR_W{1'b0}};
      slot_empty_r <= 1'b0;
      underrun_r   <= 1'b0;
      dvp_data_r   <= 8'h00;
      dvp_href_r   <= 1'b0;
      dvp_vsync_r  <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      hcnt_r       <= hcnt_nx_s;
      vcnt_r       <= vcnt_nx_s;
      tmr_r        <= tmr_nx_s;
      slot_empty_r <= slot_empty_nx_s;
      underrun_r   <= underrun_r | underrun_set_s;
      dvp_data_r   <= byte_s;
      dvp_href_r   <= (state_r == ACTIVE);
      dvp_vsync_r  <= (state_r == VSYNC);
    end
  end

endmodule

// File: tb/tb_dvp_16_8bit_tx.sv
// Bench for dvp_16_8bit_tx: per-cycle reference model plus frame-level vector table.
module tb_dvp_16_8bit_tx;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HB = 3;
  localparam int VP = 2;
  localparam int VB = 2;
  localparam int L  = 2 * H + HB;

  logic        pclk    = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] s_data  = 16'h0000;
  logic        s_sof   = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  dvp_data;
  logic        dvp_href;
  logic        dvp_vsync;
  logic        underrun;
  logic        busy;

  int total = 0;
  int bad   = 0;

  dvp_16_8bit_tx #(
    .H_ACTIVE (H), .V_ACTIVE (V), .H_BLANK (HB), .VS_PULSE (VP), .VS_BACK (VB)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .dvp_data  (dvp_data),
    .dvp_href  (dvp_href),
    .dvp_vsync (dvp_vsync),
    .underrun  (underrun),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  typedef struct packed { logic sof; logic [15:0] data; } pix_t;
  typedef struct { int gap; logic sof; logic [15:0] data; } src_t;
  typedef struct {
    int junk; logic [15:0] base; int sof_idx; int hold_idx;
    logic [7:0] e_b0; logic [7:0] e_b4; logic [7:0] e_b6; logic [7:0] e_b9;
    int e_nbytes; int e_stall; int e_vs; logic e_und;
  } vec_t;

  // Reference model state: queue of buffered pixels and frame start time.
  pix_t mq[$];
  src_t src[$];
  int   gap_cnt  = 0;
  bit   in_frame = 1'b0;
  int   fstart   = 0;
  int   cyc      = 0;
  bit   slot_ok  = 1'b0;
  bit   m_und    = 1'b0;
  bit   m_acc    = 1'b0;
  int   last_pos = -1;
  logic [7:0] e_data = 8'h00;
  bit   e_href = 1'b0, e_vsync = 1'b0, e_busy = 1'b0, e_ready = 1'b1;

  logic [7:0] cap[$];
  int   vs_rises  = 0;
  bit   vs_prev   = 1'b0;
  int   acc_cnt   = 0;
  int   stall_acc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] cap_at(input int idx);
    return (idx < cap.size()) ? {1'b0, cap[idx]} : 9'h100;
  endfunction

  // Frame timing derived from elapsed cycles since the sof pixel reached the head.
  task automatic model_step();
    int t, u, pos, tn;
    bit pop;
    cyc++;
    e_data = 8'h00; e_href = 1'b0; e_vsync = 1'b0; last_pos = -1; pop = 1'b0; t = 0;
    if (!rst_n) begin
      mq.delete(); in_frame = 1'b0; slot_ok = 1'b0; m_und = 1'b0; m_acc = 1'b0;
      e_busy = 1'b0; e_ready = 1'b1;
    end else begin
      m_acc = s_valid && (mq.size() < 2);
      if (in_frame) begin
        t = cyc - fstart - 1;
        if (t >= VP + VB && (t - VP - VB) >= V * L) in_frame = 1'b0;
      end
      if (in_frame) begin
        if (t < VP) e_vsync = 1'b1;
        else if (t >= VP + VB) begin
          u = t - VP - VB;
          pos = u % L;
          if (pos < 2 * H) begin
            e_href = 1'b1;
            last_pos = pos;
            if (pos % 2 == 0) begin
              if (mq.size() > 0) begin e_data = mq[0].data[15:8]; slot_ok = 1'b1; end
              else begin slot_ok = 1'b0; m_und = 1'b1; end
            end else if (slot_ok) begin
              e_data = mq[0].data[7:0];
              pop = 1'b1;
            end
          end
        end
      end else if (mq.size() > 0) begin
        if (mq[0].sof) begin in_frame = 1'b1; fstart = cyc; end
        else pop = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (m_acc) mq.push_back({s_sof, s_data});
      tn = cyc - fstart;
      e_busy  = in_frame && !(tn >= VP + VB && (tn - VP - VB) >= V * L);
      e_ready = (mq.size() < 2);
    end
  endtask

  task automatic add_pix(input int gap, input logic sof, input logic [15:0] data);
    src_t s;
    s.gap = gap; s.sof = sof; s.data = data;
    if (src.size() == 0) gap_cnt = gap;
    src.push_back(s);
  endtask

  task automatic tick();
    if (src.size() > 0 && gap_cnt == 0) begin
      s_valid = 1'b1; s_sof = src[0].sof; s_data = src[0].data;
    end else begin
      s_valid = 1'b0; s_sof = 1'b0; s_data = 16'($urandom);
      if (gap_cnt > 0) gap_cnt--;
    end
    @(posedge pclk);
    model_step();
    if (!rst_n) begin
      src.delete(); gap_cnt = 0;
    end else if (m_acc) begin
      void'(src.pop_front());
      acc_cnt++;
      if (src.size() > 0) gap_cnt = src[0].gap;
    end
    #1;
    chk("dvp_data", dvp_data, e_data);
    chk("dvp_href", dvp_href, e_href);
    chk("dvp_vsync", dvp_vsync, e_vsync);
    chk("underrun", underrun, m_und);
    chk("busy", busy, e_busy);
    chk("s_ready", s_ready, e_ready);
    if (dvp_href) cap.push_back(dvp_data);
    if (dvp_vsync && !vs_prev) vs_rises++;
    vs_prev = dvp_vsync;
    if (!s_ready && stall_acc < 0) stall_acc = acc_cnt;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((src.size() > 0 || in_frame || mq.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 400), 32'd1);
    tick();
    tick();
  endtask

  task automatic run_frame(input int junk, input logic [15:0] base, input int sof_idx,
                           input int hold_idx);
    cap.delete(); vs_rises = 0; acc_cnt = 0; stall_acc = -1;
    for (int j = 0; j < junk; j++) add_pix(0, 1'b0, 16'($urandom));
    for (int i = 0; i < V * H; i++)
      add_pix((i == hold_idx) ? 8 : 0, (i == 0) || (i == sof_idx), base + 16'(i) * 16'h2222);
    wait_idle("frame_timeout");
  endtask

  initial begin
    vec_t vecs[4];
    int   n;
    int   junk, np, gap;
    vecs[0] = '{0, 16'h1122, -1, -1, 8'h11, 8'h55, 8'h77, 8'hAA, 16, 2, 1, 1'b0};
    vecs[1] = '{3, 16'hAABB, -1, -1, 8'hAA, 8'hEE, 8'h11, 8'h43, 16, 5, 1, 1'b0};
    vecs[2] = '{0, 16'h0102,  2, -1, 8'h01, 8'h45, 8'h67, 8'h8A, 16, 2, 1, 1'b0};
    vecs[3] = '{0, 16'h1122, -1,  2, 8'h11, 8'h00, 8'h55, 8'h88, 16, 2, 1, 1'b1};

    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_data", dvp_data, 8'h00);
    chk("rst_href", dvp_href, 1'b0);
    chk("rst_vsync", dvp_vsync, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", s_ready, 1'b1);
    rst_n = 1'b1;
    tick(); tick();

    // Nominal, pre-frame flush, mid-frame sof and underrun frames.
    foreach (vecs[k]) begin
      run_frame(vecs[k].junk, vecs[k].base, vecs[k].sof_idx, vecs[k].hold_idx);
      chk("vec_nbytes", cap.size(), vecs[k].e_nbytes);
      chk("vec_byte0", cap_at(0), {1'b0, vecs[k].e_b0});
      chk("vec_byte4", cap_at(4), {1'b0, vecs[k].e_b4});
      chk("vec_byte6", cap_at(6), {1'b0, vecs[k].e_b6});
      chk("vec_byte9", cap_at(9), {1'b0, vecs[k].e_b9});
      chk("vec_stall_accepts", stall_acc, vecs[k].e_stall);
      chk("vec_vsync_pulses", vs_rises, vecs[k].e_vs);
      chk("vec_underrun", underrun, vecs[k].e_und);
    end

    // Reset while the next bus byte would be phase 1 of a slot.
    for (int i = 0; i < V * H; i++) add_pix(0, i == 0, 16'h5A00 + 16'(i));
    n = 0;
    while (last_pos != 2 && n < 100) begin tick(); n++; end
    chk("reach_phase1", 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_data", dvp_data, 8'h00);
    chk("mrst_href", dvp_href, 1'b0);
    chk("mrst_vsync", dvp_vsync, 1'b0);
    chk("mrst_underrun", underrun, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ready", s_ready, 1'b1);
    rst_n = 1'b1;
    tick(); tick();
    run_frame(0, 16'hC0DE, -1, -1);
    chk("post_rst_byte0", cap_at(0), 9'h0C0);
    chk("post_rst_byte1", cap_at(1), 9'h0DE);
    chk("post_rst_nbytes", cap.size(), 16);
    chk("post_rst_underrun", underrun, 1'b0);

    // Randomised frames with gaps, junk, stray sof and short/long pixel counts.
    for (int f = 0; f < 12; f++) begin
      junk = $urandom_range(0, 2);
      np   = $urandom_range(6, 10);
      for (int j = 0; j < junk; j++) add_pix($urandom_range(0, 2), 1'b0, 16'($urandom));
      for (int i = 0; i < np; i++) begin
        gap = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
        add_pix(gap, (i == 0) || ($urandom_range(0, 15) == 0), 16'($urandom));
      end
      wait_idle("rand_timeout");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
